// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with PC, IF/ID register and RUN/STALL/FLUSH FSM; FETCH_STALL_COUNT_EN builds the bubble counter
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] if_instr,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic [1:0]  fetch_state,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
    state_t state;
    logic [15:0] pc;
    assign imem_addr   = pc;
    assign if_instr    = imem_data;
    assign fetch_state = state;
    // redirect beats stall beats advance; bubbles carry the PC they replaced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            id_instr <= NOP_INSTR;
            id_pc    <= 16'h0000;
            id_valid <= 1'b0;
            state    <= RUN;
        end else begin
            id_pc <= pc;
            if (branch_taken) begin
                pc       <= branch_target;
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
                state    <= FLUSH;
            end else if (hazard) begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
                state    <= STALL;
            end else begin
                pc       <= pc + 16'd1;
                id_instr <= imem_data;
                id_valid <= 1'b1;
                state    <= RUN;
            end
        end
    end
`ifdef FETCH_STALL_COUNT_EN
    // count every bubble edge, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 16'h0000;
        else if ((branch_taken || hazard) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven scoreboard bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, hazard = 1'b0, branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_data, imem_addr, if_instr, id_instr, id_pc, stall_cnt;
    logic        id_valid;
    logic [1:0]  fetch_state;

    fetch_unit dut (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_data(imem_data), .imem_addr(imem_addr),
        .if_instr(if_instr), .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .fetch_state(fetch_state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    assign imem_data = imem_addr ^ 16'hBEEF;

    typedef struct packed {
        logic        h;
        logic        b;
        logic [15:0] tgt;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] ipc;
        logic        v;
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [15:0] ecnt(input logic [15:0] c);
`ifdef FETCH_STALL_COUNT_EN
        return c;
`else
        return 16'h0000 & c;
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t r);
        vec_t e;
        hazard = r.h;
        branch_taken = r.b;
        branch_target = r.tgt;
        q.push_back(r);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("if_instr", if_instr, e.addr ^ 16'hBEEF);
        chk("id_instr", id_instr, e.instr);
        chk("id_pc", id_pc, e.ipc);
        chk("id_valid", 16'(id_valid), 16'(e.v));
        chk("fetch_state", 16'(fetch_state), 16'(e.st));
        chk("stall_cnt", stall_cnt, ecnt(e.cnt));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, imem_addr, 16'h0000);
        chk({tag, "_instr"}, id_instr, 16'h0000);
        chk({tag, "_pc"}, id_pc, 16'h0000);
        chk({tag, "_valid"}, 16'(id_valid), 16'h0000);
        chk({tag, "_state"}, 16'(fetch_state), 16'h0000);
        chk({tag, "_cnt"}, stall_cnt, 16'h0000);
    endtask

    initial begin
        //                  h     b     tgt       addr      instr     ipc       v     st    cnt
        tbl.push_back(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0001, 16'hBEEF, 16'h0000, 1'b1, 2'd0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0002, 16'hBEEE, 16'h0001, 1'b1, 2'd0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0003, 16'hBEED, 16'h0002, 1'b1, 2'd0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0003, 1'b0, 2'd2, 16'd1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0005, 1'b0, 2'd1, 16'd2});
        tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0005, 1'b0, 2'd1, 16'd3});
        tbl.push_back(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0006, 16'hBEEA, 16'h0005, 1'b1, 2'd0, 16'd3});
        tbl.push_back(vec_t'{1'b1, 1'b1, 16'h0040, 16'h0040, 16'h0000, 16'h0006, 1'b0, 2'd2, 16'd4});
        tbl.push_back(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0041, 16'hBEAF, 16'h0040, 1'b1, 2'd0, 16'd4});
        tbl.push_back(vec_t'{1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000, 16'h0041, 1'b0, 2'd2, 16'd5});
        tbl.push_back(vec_t'{1'b0, 1'b1, 16'h0200, 16'h0200, 16'h0000, 16'h0100, 1'b0, 2'd2, 16'd6});
        tbl.push_back(vec_t'{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0200, 1'b0, 2'd2, 16'd7});
        tbl.push_back(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4110, 16'hFFFF, 1'b1, 2'd0, 16'd7});
        tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd1, 16'd8});
        tbl.push_back(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0001, 16'hBEEF, 16'h0000, 1'b1, 2'd0, 16'd8});

        #1;
        chk_reset("reset");
        #1 rst = 1'b0;
        foreach (tbl[i]) step(tbl[i]);

        step(vec_t'{1'b0, 1'b1, 16'h0009, 16'h0009, 16'h0000, 16'h0001, 1'b0, 2'd2, 16'd9});
        step(vec_t'{1'b1, 1'b0, 16'h0000, 16'h0009, 16'h0000, 16'h0009, 1'b0, 2'd1, 16'd10});
        #3 rst = 1'b1;
        #1;
        chk_reset("midstall_reset");
        #1 rst = 1'b0;
        step(vec_t'{1'b0, 1'b0, 16'h0000, 16'h0001, 16'hBEEF, 16'h0000, 1'b1, 2'd0, 16'd0});

        hazard = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_cnt", stall_cnt, ecnt(16'hFFFF));
        chk("sat_addr", imem_addr, 16'h0001);
        chk("sat_valid", 16'(id_valid), 16'h0000);
        chk("sat_state", 16'(fetch_state), 16'h0001);
        hazard = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_release_instr", id_instr, 16'hBEEE);
        chk("sat_release_pc", id_pc, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000: bubble word injected into ID (ADD r0,r0,r0).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hazard  input  1  stall request from hazard detection, combinational on this cycle's if_instr.
REQ-006 branch_taken  input  1  redirect request (taken branch, jump, RET resolved).
REQ-007 branch_target  input  16  redirect PC, valid when branch_taken=1.
REQ-008 imem_data  input  16  instruction word at imem_addr, combinational read.
REQ-009 imem_addr  output  16  current PC.
REQ-010 if_instr  output  16  instruction in IF this cycle, to hazard detection.
REQ-011 id_instr  output  16  IF/ID pipeline register instruction.
REQ-012 id_pc  output  16  PC of id_instr.
REQ-013 id_valid  output  1  1 = id_instr is a real fetched instruction; 0 = bubble.
REQ-014 fetch_state  output  2  registered FSM state: 2'd0 RUN, 2'd1 STALL, 2'd2 FLUSH.
REQ-015 stall_cnt  output  16  bubble-cycle counter (see Configuration).

Function
REQ-016 imem_addr SHALL equal pc; if_instr SHALL equal imem_data with zero latency.
REQ-017 Per-edge priority SHALL be: branch_taken > hazard > normal advance.
REQ-018 branch_taken=1: pc <= branch_target; id_instr <= NOP_INSTR; id_pc <= pc; id_valid <= 0; fetch_state <= FLUSH.
REQ-019 hazard=1, branch_taken=0: pc holds; id_instr <= NOP_INSTR; id_pc <= pc; id_valid <= 0; fetch_state <= STALL.
REQ-020 Neither asserted: pc <= pc+1 (16-bit, 16'hFFFF wraps to 16'h0000); id_instr <= imem_data; id_pc <= pc; id_valid <= 1; fetch_state <= RUN.
REQ-021 A stalled instruction SHALL be re-presented on if_instr every cycle until hazard drops, then latched into ID exactly once.
REQ-022 branch_taken and hazard together SHALL redirect; the stalled IF instruction is discarded.
REQ-023 Consecutive branch_taken cycles SHALL each redirect; the last target wins.
REQ-024 Stall length SHALL be unbounded; no internal timeout.
REQ-025 FSM transitions SHALL depend only on the current inputs per REQ-017; any state can reach any state in one cycle.
REQ-026 Undefined (x) bits in imem_data SHALL only propagate to id_instr on a normal advance.

Reset
REQ-027 While rst=1, asynchronously: pc=RESET_PC, id_instr=NOP_INSTR, id_pc=16'h0000, id_valid=0, fetch_state=RUN, stall_cnt=0.
REQ-028 The first rising edge with rst=0 SHALL perform a normal advance from RESET_PC unless hazard or branch_taken is asserted.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL abandon the operation; no pending redirect survives reset.

Configuration
REQ-030 Macro FETCH_STALL_COUNT_EN defined: stall_cnt increments on every edge where REQ-018 or REQ-019 applies, saturating at 16'hFFFF.
REQ-031 Macro FETCH_STALL_COUNT_EN undefined: the stall_cnt port remains and is tied to 16'h0000; no counter register is built.

Verification
REQ-032 Reset release, imem[0..2]=A,B,C, no hazard -> id_instr A,B,C on edges 1-3; id_pc 0,1,2; id_valid=1; imem_addr=3.
REQ-033 hazard=1 for 2 cycles at pc=5 -> imem_addr stays 5; two bubbles (id_valid=0, id_instr=16'h0000); then id_instr=imem[5], id_pc=5; stall_cnt=2 when enabled.
REQ-034 branch_taken=1, target=16'h0040, during hazard -> next imem_addr=16'h0040; id_valid=0; fetch_state=FLUSH; next edge id_pc=16'h0040.
REQ-035 pc=16'hFFFF, normal advance -> imem_addr=16'h0000; id_pc=16'hFFFF.
REQ-036 rst pulsed between edges during a stall at pc=9 -> immediately pc=RESET_PC, id_valid=0, fetch_state=RUN, stall_cnt=0.
REQ-037 Enabled build, hazard held 70000 cycles -> stall_cnt saturates at 16'hFFFF; disabled build -> stall_cnt=0 throughout.
